// File: rtl/req_encoder_16_to_4.sv
// Captures a 16-bit request vector and offers each set index in priority order over a valid/ack handshake.
// Optional REQ_ENC_MERGE_EN: a capture while serving merges new requests into the pending set.
module req_encoder_16_to_4 #(
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req_line,
  input  logic        capture,
  input  logic        ack,
  output logic [3:0]  c_addr,
  output logic        valid,
  output logic        busy,
  output logic [4:0]  count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_n_s;
  logic [15:0] pending_r;
  logic [15:0] pending_n_s;
  logic [15:0] base_s;
  logic [15:0] merged_s;
  logic [3:0]  c_addr_n_s;
  logic        valid_n_s;
  logic        busy_n_s;
  logic [4:0]  count_n_s;

  // The last match in the scan wins, so the scan direction sets the priority.
  function automatic logic [3:0] first_index(input logic [15:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 15; i >= 0; i--) idx = vec[i] ? i[3:0] : idx;
    end else begin
      for (int i = 0; i < 16; i++) idx = vec[i] ? i[3:0] : idx;
    end
    return idx;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] vec);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, vec[i]};
    return cnt;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_n_s   = state_r;
    pending_n_s = pending_r;
    c_addr_n_s  = c_addr;
    valid_n_s   = valid;
    busy_n_s    = busy;
    count_n_s   = count;
    base_s      = pending_r;
    merged_s    = pending_r;
    case (state_r)
      IDLE: begin
        if (capture && (req_line != 16'h0000)) begin
          state_n_s   = SERVE;
          pending_n_s = req_line;
          c_addr_n_s  = first_index(req_line);
          valid_n_s   = 1'b1;
          busy_n_s    = 1'b1;
          count_n_s   = popcount(req_line);
        end else begin
          state_n_s = IDLE;
        end
      end
      SERVE: begin
        base_s = (valid && ack) ? (pending_r & ~(16'h0001 << c_addr)) : pending_r;
`ifdef REQ_ENC_MERGE_EN
        merged_s = capture ? (base_s | req_line) : base_s;
`else
        merged_s = base_s;
`endif
        pending_n_s = merged_s;
        if (merged_s == 16'h0000) begin
          state_n_s  = IDLE;
          c_addr_n_s = 4'd0;
          valid_n_s  = 1'b0;
          busy_n_s   = 1'b0;
          count_n_s  = 5'd0;
        end else begin
          state_n_s  = SERVE;
          c_addr_n_s = first_index(merged_s);
          valid_n_s  = 1'b1;
          busy_n_s   = 1'b1;
          count_n_s  = popcount(merged_s);
        end
      end
      default: begin
        state_n_s   = IDLE;
        pending_n_s = 16'h0000;
        c_addr_n_s  = 4'd0;
        valid_n_s   = 1'b0;
        busy_n_s    = 1'b0;
        count_n_s   = 5'd0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= 16'h0000;
      c_addr    <= 4'd0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      count     <= 5'd0;
    end else begin
      state_r   <= state_n_s;
      pending_r <= pending_n_s;
      c_addr    <= c_addr_n_s;
      valid     <= valid_n_s;
      busy      <= busy_n_s;
      count     <= count_n_s;
    end
  end

endmodule

// File: tb/tb_req_encoder_16_to_4.sv
// Scoreboard bench: stimulus pushes expected (c_addr, count) per transfer; monitors pop on each handshake.
module tb_req_encoder_16_to_4;

  typedef struct {
    logic [3:0] addr;
    logic [4:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] req_line;
  logic        capture;
  logic        ack;
  logic [3:0]  c_addr;
  logic        valid;
  logic        busy;
  logic [4:0]  count;

  logic [15:0] m_req_line;
  logic        m_capture;
  logic        m_ack;
  logic [3:0]  m_c_addr;
  logic        m_valid;
  logic        m_busy;
  logic [4:0]  m_count;

  exp_t exp_q[$];
  exp_t exp_m_q[$];
  int   checks;
  int   errors;

  req_encoder_16_to_4 #(.LSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_line(req_line), .capture(capture), .ack(ack),
    .c_addr(c_addr), .valid(valid), .busy(busy), .count(count)
  );

  req_encoder_16_to_4 #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .req_line(m_req_line), .capture(m_capture), .ack(m_ack),
    .c_addr(m_c_addr), .valid(m_valid), .busy(m_busy), .count(m_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [4:0] c);
    exp_t e;
    e.addr = a;
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  task automatic push_m(input logic [3:0] a, input logic [4:0] c);
    exp_t e;
    e.addr = a;
    e.cnt  = c;
    exp_m_q.push_back(e);
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin
    if (rst_n && valid && ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lsb_unexpected_offer: got c_addr %0d count %0d expected none", c_addr, count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("lsb_offer_addr", {12'd0, c_addr}, {12'd0, e.addr});
        chk("lsb_offer_count", {11'd0, count}, {11'd0, e.cnt});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ack) begin
      if (exp_m_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL msb_unexpected_offer: got c_addr %0d count %0d expected none", m_c_addr, m_count);
      end else begin
        exp_t e;
        e = exp_m_q.pop_front();
        chk("msb_offer_addr", {12'd0, m_c_addr}, {12'd0, e.addr});
        chk("msb_offer_count", {11'd0, m_count}, {11'd0, e.cnt});
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req_line   = 16'h0000;
    capture    = 1'b0;
    ack        = 1'b0;
    m_req_line = 16'h0000;
    m_capture  = 1'b0;
    m_ack      = 1'b0;

    // Reset, with capture asserted to show reset dominates
    tick();
    req_line = 16'hFFFF;
    capture  = 1'b1;
    tick();
    chk("rst_c_addr", {12'd0, c_addr}, 16'h0000);
    chk("rst_valid", {15'd0, valid}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_count", {11'd0, count}, 16'h0000);
    capture = 1'b0;

    // 0x8421 with ack held: 0,5,10,15 back to back
    rst_n    = 1'b1;
    req_line = 16'h8421;
    capture  = 1'b1;
    ack      = 1'b1;
    push(4'd0, 5'd4); push(4'd5, 5'd3); push(4'd10, 5'd2); push(4'd15, 5'd1);
    tick();
    capture = 1'b0;
    chk("cap_latency_valid", {15'd0, valid}, 16'h0001);
    chk("cap_busy", {15'd0, busy}, 16'h0001);
    for (int i = 0; i < 4; i++) tick();
    chk("drain_valid", {15'd0, valid}, 16'h0000);
    chk("drain_busy", {15'd0, busy}, 16'h0000);
    chk("drain_count", {11'd0, count}, 16'h0000);
    chk("drain_c_addr", {12'd0, c_addr}, 16'h0000);
    ack = 1'b0;

    // Hold without ack
    req_line = 16'h0010;
    capture  = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_c_addr", {12'd0, c_addr}, 16'h0004);
      chk("hold_valid", {15'd0, valid}, 16'h0001);
      chk("hold_count", {11'd0, count}, 16'h0001);
    end
    push(4'd4, 5'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("single_ack_valid", {15'd0, valid}, 16'h0000);

    // Capture of an empty vector in IDLE
    req_line = 16'h0000;
    capture  = 1'b1;
    tick();
    capture = 1'b0;
    chk("empty_cap_valid", {15'd0, valid}, 16'h0000);
    chk("empty_cap_busy", {15'd0, busy}, 16'h0000);
    chk("empty_cap_count", {11'd0, count}, 16'h0000);

    // Capture during SERVE together with ack
    req_line = 16'h0006;
    capture  = 1'b1;
    tick();
    chk("srv_c_addr", {12'd0, c_addr}, 16'h0001);
    chk("srv_count", {11'd0, count}, 16'h0002);
    req_line = 16'h0001;
    ack      = 1'b1;
    push(4'd1, 5'd2);
    tick();
    capture = 1'b0;
`ifdef REQ_ENC_MERGE_EN
    chk("merge_c_addr", {12'd0, c_addr}, 16'h0000);
    chk("merge_count", {11'd0, count}, 16'h0002);
    push(4'd0, 5'd2); push(4'd2, 5'd1);
    tick(); tick();
`else
    chk("nomerge_c_addr", {12'd0, c_addr}, 16'h0002);
    chk("nomerge_count", {11'd0, count}, 16'h0001);
    push(4'd2, 5'd1);
    tick();
`endif
    ack = 1'b0;
    chk("srv_done_valid", {15'd0, valid}, 16'h0000);

    // Reset in the middle of serving 0x00FF
    req_line = 16'h00FF;
    capture  = 1'b1;
    ack      = 1'b1;
    push(4'd0, 5'd8); push(4'd1, 5'd7);
    tick();
    capture = 1'b0;
    tick(); tick();
    chk("pre_rst_c_addr", {12'd0, c_addr}, 16'h0002);
    chk("pre_rst_count", {11'd0, count}, 16'h0006);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_c_addr", {12'd0, c_addr}, 16'h0000);
    chk("mid_rst_valid", {15'd0, valid}, 16'h0000);
    chk("mid_rst_busy", {15'd0, busy}, 16'h0000);
    chk("mid_rst_count", {11'd0, count}, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_offer", {15'd0, valid}, 16'h0000);
    end
    ack = 1'b0;

    // First capture right after reset release
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    req_line = 16'h0080;
    capture  = 1'b1;
    tick();
    capture = 1'b0;
    chk("first_cap_valid", {15'd0, valid}, 16'h0001);
    chk("first_cap_c_addr", {12'd0, c_addr}, 16'h0007);
    push(4'd7, 5'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("first_cap_done", {15'd0, valid}, 16'h0000);

    // Highest-first instance
    m_req_line = 16'h0003;
    m_capture  = 1'b1;
    m_ack      = 1'b1;
    push_m(4'd1, 5'd2); push_m(4'd0, 5'd1);
    tick();
    m_capture = 1'b0;
    chk("msb_first_c_addr", {12'd0, m_c_addr}, 16'h0001);
    tick();
    chk("msb_second_c_addr", {12'd0, m_c_addr}, 16'h0000);
    tick();
    chk("msb_idle_valid", {15'd0, m_valid}, 16'h0000);
    chk("msb_idle_busy", {15'd0, m_busy}, 16'h0000);
    m_req_line = 16'h8421;
    m_capture  = 1'b1;
    push_m(4'd15, 5'd4); push_m(4'd10, 5'd3); push_m(4'd5, 5'd2); push_m(4'd0, 5'd1);
    tick();
    m_capture = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    m_ack = 1'b0;
    chk("msb_drain_valid", {15'd0, m_valid}, 16'h0000);

    tick(); tick();
    chk("lsb_queue_empty", exp_q.size()[15:0], 16'h0000);
    chk("msb_queue_empty", exp_m_q.size()[15:0], 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_encoder_16_to_4.md
REQ_ENCODER_16_TO_4 -- requirements
Module: req_encoder_16_to_4

Interface
REQ-001 Parameter LSB_FIRST, default 1, service order: 1 = lowest set index first, 0 = highest set index first.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_line  input  16  one-hot/multi-hot request vector, one bit per register/target index.
REQ-005 capture  input  1  strobe: sample req_line into pending set.
REQ-006 ack  input  1  consumer accepts current c_addr.
REQ-007 c_addr  output  4  registered encoded index of request being offered.
REQ-008 valid  output  1  registered; c_addr holds a pending index.
REQ-009 busy  output  1  registered; high in state SERVE.
REQ-010 count  output  5  registered; number of set bits in pending (0..16).

Function
REQ-011 Internal 16-bit register pending; FSM states IDLE and SERVE.
REQ-012 IDLE, capture=1, req_line!=0: pending<=req_line; c_addr<=first index per LSB_FIRST; valid<=1; busy<=1; count<=popcount(req_line); go SERVE.
REQ-013 IDLE, capture=1, req_line=0: no state change; outputs unchanged.
REQ-014 Latency capture edge to valid=1: exactly one clock.
REQ-015 Handshake: transfer occurs on a rising edge with valid=1 and ack=1; ack with valid=0 is ignored.
REQ-016 Transfer: pending_next = pending with bit c_addr cleared; c_addr<=first index of pending_next; count decrements by 1.
REQ-017 Transfers sustain one per clock; no bubble between back-to-back acks.
REQ-018 Last bit transferred (pending_next=0): valid<=0, busy<=0, c_addr<=0, count<=0, go IDLE same edge.
REQ-019 While valid=1 and ack=0, c_addr, valid, count hold stable.
REQ-020 Each captured index is offered exactly once; offered order strictly ascending (LSB_FIRST=1) or descending (LSB_FIRST=0).
REQ-021 capture in SERVE handled per REQ-027/REQ-028.
REQ-022 count equals popcount(pending) on every cycle; no wrap, max 16.

Reset
REQ-023 rst_n=0 at rising edge: pending=0, state IDLE, c_addr=0, valid=0, busy=0, count=0.
REQ-024 Reset mid-SERVE discards all pending requests; no transfer completes on that edge even if ack=1.
REQ-025 Reset dominates capture and ack on the same edge.
REQ-026 First capture accepted on first edge with rst_n=1.

Configuration
REQ-027 Macro REQ_ENC_MERGE_EN defined: capture in SERVE merges, pending_next = (pending with acked bit cleared if transferring) | req_line; c_addr re-evaluated from pending_next; count updated; a re-requested acked index is re-offered later.
REQ-028 Macro REQ_ENC_MERGE_EN undefined: capture in SERVE ignored entirely; req_line not sampled.

Verification
REQ-029 Reset, capture req_line=16'h8421, ack held 1 -> c_addr 0,5,10,15 on consecutive cycles, count 4,3,2,1, then valid=0, busy=0.
REQ-030 LSB_FIRST=0, capture 16'h0003, ack=1 -> c_addr 1 then 0, then IDLE.
REQ-031 Capture 16'h0010, hold ack=0 five cycles -> c_addr=4, valid=1 stable; ack one cycle -> valid=0 next edge.
REQ-032 Capture 16'h00FF, rst_n=0 after two transfers -> next edge all outputs 0, pending cleared; no further offers.
REQ-033 In SERVE with pending 16'h0006, c_addr=1, capture 16'h0001 plus ack: merge build -> c_addr=0, count=2; non-merge build -> c_addr=2, count=1.
REQ-034 IDLE, capture with req_line=0 -> valid, busy, count remain 0.
